// File: rtl/sys_rx_cmd_ctrl_if.sv
// Bus between the UART RX side, the register file / ALU and the receive command controller.
// master = controller side, slave = UART RX / register file / ALU side.
interface sys_rx_cmd_ctrl_if #(
    parameter int Width      = 8,
    parameter int Addr_Width = 4
);
    logic [Width-1:0]      RX_P_Data;
    logic                  RX_D_VLD;
    logic                  ALU_OUT_VLD;
    logic                  WrEn;
    logic                  RdEn;
    logic [Addr_Width-1:0] Address;
    logic [Width-1:0]      WrData;
    logic                  ALU_EN;
    logic [3:0]            ALU_FUN;
    logic                  CLK_GATE_EN;

    modport master (
        input  RX_P_Data, RX_D_VLD, ALU_OUT_VLD,
        output WrEn, RdEn, Address, WrData, ALU_EN, ALU_FUN, CLK_GATE_EN
    );

    modport slave (
        output RX_P_Data, RX_D_VLD, ALU_OUT_VLD,
        input  WrEn, RdEn, Address, WrData, ALU_EN, ALU_FUN, CLK_GATE_EN
    );
endinterface

// File: rtl/sys_rx_cmd_ctrl.sv
// Receive-side command parser: turns UART byte frames into register-file writes/reads
// and ALU starts, with a silence timeout that abandons incomplete frames.
module sys_rx_cmd_ctrl #(
    parameter int Width      = 8,
    parameter int Addr_Width = 4,
    parameter int Timeout    = 1024
) (
    input  logic                  CLK,
    input  logic                  RST,
    sys_rx_cmd_ctrl_if.master     bus
);
    localparam int CW = $clog2(Timeout);

    localparam logic [Width-1:0] CMD_WR  = Width'(8'hAA);
    localparam logic [Width-1:0] CMD_RD  = Width'(8'hBB);
    localparam logic [Width-1:0] CMD_ALU = Width'(8'hCC);
    localparam logic [Width-1:0] CMD_FUN = Width'(8'hDD);

    typedef enum logic [2:0] {
        S_IDLE, S_WR_ADDR, S_WR_DATA, S_RD_ADDR, S_OPA, S_OPB, S_FUN, S_ALU_WAIT
    } state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [Addr_Width-1:0] wr_addr_q, wr_addr_d;
    logic                  wr_en_q, wr_en_d;
    logic                  rd_en_q, rd_en_d;
    logic                  alu_en_q, alu_en_d;
    logic [Addr_Width-1:0] address_q, address_d;
    logic [Width-1:0]      wr_data_q, wr_data_d;
    logic [3:0]            alu_fun_q, alu_fun_d;
    logic                  gate_q, gate_d;

    logic                  expire_s;
    logic                  alu_done_s;
    logic [Addr_Width-1:0] addr_byte_s;

    // Next-state, strobe and hold-register computation.
    always_comb begin
        state_d   = state_q;
        wr_addr_d = wr_addr_q;
        wr_en_d   = 1'b0;
        rd_en_d   = 1'b0;
        alu_en_d  = 1'b0;
        address_d = address_q;
        wr_data_d = wr_data_q;
        alu_fun_d = alu_fun_q;

        expire_s    = (cnt_q == CW'(Timeout - 1));
        // A result in the ALU_EN cycle itself belongs to a previous operation.
        alu_done_s  = bus.ALU_OUT_VLD && !alu_en_q;
        addr_byte_s = bus.RX_P_Data[Addr_Width-1:0];

        case (state_q)
            S_IDLE: begin
                if (bus.RX_D_VLD) begin
                    if (bus.RX_P_Data == CMD_WR)       state_d = S_WR_ADDR;
                    else if (bus.RX_P_Data == CMD_RD)  state_d = S_RD_ADDR;
                    else if (bus.RX_P_Data == CMD_ALU) state_d = S_OPA;
                    else if (bus.RX_P_Data == CMD_FUN) state_d = S_FUN;
                    else                               state_d = S_IDLE;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WR_ADDR: begin
                if (bus.RX_D_VLD) begin
                    wr_addr_d = addr_byte_s;
                    state_d   = S_WR_DATA;
                end else if (expire_s) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_WR_ADDR;
                end
            end
            S_WR_DATA: begin
                if (bus.RX_D_VLD) begin
                    wr_en_d   = 1'b1;
                    address_d = wr_addr_q;
                    wr_data_d = bus.RX_P_Data;
                    state_d   = S_IDLE;
                end else if (expire_s) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_WR_DATA;
                end
            end
            S_RD_ADDR: begin
                if (bus.RX_D_VLD) begin
                    rd_en_d   = 1'b1;
                    address_d = addr_byte_s;
                    state_d   = S_IDLE;
                end else if (expire_s) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_RD_ADDR;
                end
            end
            S_OPA: begin
                if (bus.RX_D_VLD) begin
                    wr_en_d   = 1'b1;
                    address_d = Addr_Width'(0);
                    wr_data_d = bus.RX_P_Data;
                    state_d   = S_OPB;
                end else if (expire_s) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_OPA;
                end
            end
            S_OPB: begin
                if (bus.RX_D_VLD) begin
                    wr_en_d   = 1'b1;
                    address_d = Addr_Width'(1);
                    wr_data_d = bus.RX_P_Data;
                    state_d   = S_FUN;
                end else if (expire_s) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_OPB;
                end
            end
            S_FUN: begin
                if (bus.RX_D_VLD) begin
                    alu_en_d  = 1'b1;
                    alu_fun_d = bus.RX_P_Data[3:0];
                    state_d   = S_ALU_WAIT;
                end else if (expire_s) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_FUN;
                end
            end
            S_ALU_WAIT: begin
                if (alu_done_s || expire_s) state_d = S_IDLE;
                else                        state_d = S_ALU_WAIT;
            end
            default: state_d = S_IDLE;
        endcase

        // Gate opens in OPB so the ALU clock runs before ALU_EN.
        gate_d = (state_d == S_OPB) || (state_d == S_FUN) || (state_d == S_ALU_WAIT);

        if ((state_d != state_q) || (state_q == S_IDLE)) cnt_d = {CW{1'b0}};
        else                                             cnt_d = cnt_q + CW'(1);
    end

    // State, timeout counter and registered outputs.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q   <= S_IDLE;
            cnt_q     <= {CW{1'b0}};
            wr_addr_q <= {Addr_Width{1'b0}};
            wr_en_q   <= 1'b0;
            rd_en_q   <= 1'b0;
            alu_en_q  <= 1'b0;
            address_q <= {Addr_Width{1'b0}};
            wr_data_q <= {Width{1'b0}};
            alu_fun_q <= 4'h0;
            gate_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            wr_addr_q <= wr_addr_d;
            wr_en_q   <= wr_en_d;
            rd_en_q   <= rd_en_d;
            alu_en_q  <= alu_en_d;
            address_q <= address_d;
            wr_data_q <= wr_data_d;
            alu_fun_q <= alu_fun_d;
            gate_q    <= gate_d;
        end
    end

    assign bus.WrEn        = wr_en_q;
    assign bus.RdEn        = rd_en_q;
    assign bus.ALU_EN      = alu_en_q;
    assign bus.Address     = address_q;
    assign bus.WrData      = wr_data_q;
    assign bus.ALU_FUN     = alu_fun_q;
    assign bus.CLK_GATE_EN = gate_q;
endmodule

// File: tb/tb_sys_rx_cmd_ctrl.sv
// Bench for sys_rx_cmd_ctrl: directed frames plus random byte traffic, checked every
// cycle against a frame-level model (queue of accepted bytes and a silence counter).
module tb_sys_rx_cmd_ctrl;
    localparam int T = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    sys_rx_cmd_ctrl_if #(.Width(8), .Addr_Width(4)) bus ();

    sys_rx_cmd_ctrl #(.Width(8), .Addr_Width(4), .Timeout(T)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Model: bytes of the open frame, silence counter, pending ALU result, expected outputs.
    int   frame[$];
    int   idle_cnt = 0;
    bit   waiting  = 1'b0;
    bit   e_wr = 1'b0, e_rd = 1'b0, e_alu = 1'b0, e_gate = 1'b0;
    int   e_addr = 0, e_wdata = 0, e_fun = 0;

    task automatic model_reset();
        frame.delete();
        idle_cnt = 0; waiting = 1'b0;
        e_wr = 1'b0; e_rd = 1'b0; e_alu = 1'b0; e_gate = 1'b0;
        e_addr = 0; e_wdata = 0; e_fun = 0;
    endtask

    task automatic frame_done();
        int n;
        n = frame.size();
        if (frame[0] == 'hAA && n == 3) begin
            e_wr = 1'b1; e_addr = frame[1] % 16; e_wdata = frame[2]; frame.delete();
        end else if (frame[0] == 'hBB && n == 2) begin
            e_rd = 1'b1; e_addr = frame[1] % 16; frame.delete();
        end else if (frame[0] == 'hCC && (n == 2 || n == 3)) begin
            e_wr = 1'b1; e_addr = n - 2; e_wdata = frame[n-1];
        end else if ((frame[0] == 'hCC && n == 4) || (frame[0] == 'hDD && n == 2)) begin
            e_alu = 1'b1; e_fun = frame[n-1] % 16; frame.delete(); waiting = 1'b1;
        end
    endtask

    task automatic model_step(input bit vld, input int b, input bit av);
        bit prev_alu;
        prev_alu = e_alu;
        e_wr = 1'b0; e_rd = 1'b0; e_alu = 1'b0;
        if (waiting) begin
            if ((av && !prev_alu) || idle_cnt == T - 1) begin
                waiting = 1'b0; idle_cnt = 0;
            end else idle_cnt++;
        end else if (frame.size() == 0) begin
            if (vld && (b == 'hAA || b == 'hBB || b == 'hCC || b == 'hDD)) begin
                frame.push_back(b); idle_cnt = 0;
            end
        end else if (vld) begin
            frame.push_back(b); idle_cnt = 0; frame_done();
        end else if (idle_cnt == T - 1) begin
            frame.delete(); idle_cnt = 0;
        end else idle_cnt++;
        e_gate = waiting || (frame.size() >= 2 && frame[0] == 'hCC) ||
                 (frame.size() >= 1 && frame[0] == 'hDD);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s at %0t: observed=%0h expected=%0h", tag, $time, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("WrEn",        {31'd0, bus.WrEn},        e_wr);
        chk("RdEn",        {31'd0, bus.RdEn},        e_rd);
        chk("ALU_EN",      {31'd0, bus.ALU_EN},      e_alu);
        chk("CLK_GATE_EN", {31'd0, bus.CLK_GATE_EN}, e_gate);
        chk("Address",     {28'd0, bus.Address},     e_addr);
        chk("WrData",      {24'd0, bus.WrData},      e_wdata);
        chk("ALU_FUN",     {28'd0, bus.ALU_FUN},     e_fun);
    endtask

    // One clock: drive inputs, let the edge happen, advance the model, compare outputs.
    task automatic step(input bit vld, input logic [7:0] b, input bit av);
        bus.RX_D_VLD    = vld;
        bus.RX_P_Data   = vld ? b : 8'($urandom);
        bus.ALU_OUT_VLD = av;
        @(posedge clk);
        model_step(vld, int'(b), av);
        #1;
        check_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0);
    endtask

    initial begin
        bus.RX_D_VLD = 1'b0; bus.RX_P_Data = 8'h00; bus.ALU_OUT_VLD = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1 check_all();
        rst = 1'b1;

        // Register write, then register read.
        step(1'b1, 8'hAA, 1'b0); step(1'b1, 8'h05, 1'b0); step(1'b1, 8'h3C, 1'b0);
        idle(2);
        step(1'b1, 8'hBB, 1'b0); step(1'b1, 8'hF7, 1'b0);
        idle(2);

        // ALU with operands, result three cycles after ALU_EN.
        step(1'b1, 8'hCC, 1'b0); step(1'b1, 8'h12, 1'b0);
        step(1'b1, 8'h34, 1'b0); step(1'b1, 8'h01, 1'b0);
        step(1'b0, 8'h00, 1'b0); step(1'b0, 8'h00, 1'b0); step(1'b0, 8'h00, 1'b1);
        idle(2);

        // Junk byte, ALU without operands, result in ALU_EN cycle ignored, byte in wait dropped.
        step(1'b1, 8'h55, 1'b0); step(1'b1, 8'hDD, 1'b0); step(1'b1, 8'h08, 1'b1);
        step(1'b1, 8'hAA, 1'b0); step(1'b1, 8'h02, 1'b0);
        step(1'b0, 8'h00, 1'b1);
        idle(2);

        // Timeout: full silence abandons, byte on the last allowed cycle is accepted.
        step(1'b1, 8'hAA, 1'b0); step(1'b1, 8'h03, 1'b0);
        idle(T);
        step(1'b1, 8'hAA, 1'b0); step(1'b1, 8'h03, 1'b0); step(1'b1, 8'hFF, 1'b0);
        step(1'b1, 8'hAA, 1'b0); step(1'b1, 8'h03, 1'b0);
        idle(T - 1);
        step(1'b1, 8'h77, 1'b0);
        step(1'b1, 8'hDD, 1'b0); step(1'b1, 8'h0B, 1'b0);
        idle(T + 2);

        // Asynchronous reset between the A and B operand bytes.
        step(1'b1, 8'hCC, 1'b0); step(1'b1, 8'h12, 1'b0);
        #1 rst = 1'b0;
        #1 model_reset();
        check_all();
        #1 rst = 1'b1;
        step(1'b1, 8'h34, 1'b0); step(1'b1, 8'h01, 1'b0);
        idle(2);

        // Random traffic biased towards command bytes, with occasional long silences.
        for (int i = 0; i < 1500; i++) begin
            int r;
            logic [7:0] b;
            r = int'($urandom_range(0, 99));
            if (r < 3) begin
                idle(T + int'($urandom_range(0, 3)) - 2);
            end else begin
                if ($urandom_range(0, 2) == 0) begin
                    case ($urandom_range(0, 3))
                        0:       b = 8'hAA;
                        1:       b = 8'hBB;
                        2:       b = 8'hCC;
                        default: b = 8'hDD;
                    endcase
                end else begin
                    b = 8'($urandom);
                end
                step(r < 55, b, $urandom_range(0, 6) == 0);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/sys_rx_cmd_ctrl.md
# sys_rx_cmd_ctrl

Receive-side system controller. It parses byte frames delivered by the UART receiver and sequences the register file and the ALU: register writes, register reads, and ALU operations with or without new operands. It sits between the UART RX deserializer and the register file / ALU / ALU clock gate. Results are returned to the host by the existing TX-side FSM.

## Interface
- Width, 8, data byte / register width
- Addr_Width, 4, register file address width
- Timeout, 1024, CLK cycles without a byte (or ALU result) before an open frame is abandoned; must be ≥ 2

- CLK  in  1  system clock
- RST  in  1  reset, asynchronous, active-low
- RX_P_Data  in  Width  received byte, valid only while RX_D_VLD=1
- RX_D_VLD  in  1  one-cycle pulse per received byte
- ALU_OUT_VLD  in  1  ALU result valid pulse
- WrEn  out  1  register file write strobe, one cycle
- RdEn  out  1  register file read strobe, one cycle
- Address  out  Addr_Width  register file address
- WrData  out  Width  register file write data
- ALU_EN  out  1  ALU start, one-cycle pulse
- ALU_FUN  out  4  ALU function code
- CLK_GATE_EN  out  1  enable for the ALU clock gate

## Operation
- Command bytes, accepted in IDLE only: 0xAA = reg write (addr, data); 0xBB = reg read (addr); 0xCC = ALU with operands (A, B, fun); 0xDD = ALU without operands (fun). Any other byte in IDLE is discarded and the FSM stays in IDLE.
- States and transitions:
  - IDLE: 0xAA→WR_ADDR; 0xBB→RD_ADDR; 0xCC→OPA; 0xDD→FUN.
  - WR_ADDR: on a byte, latch the address and go to WR_DATA.
  - WR_DATA: on a byte, WrEn pulse with Address=latched address and WrData=byte; go to IDLE.
  - RD_ADDR: on a byte, RdEn pulse with Address=byte[Addr_Width-1:0]; go to IDLE.
  - OPA: on a byte, WrEn pulse with Address=0 and WrData=byte; go to OPB.
  - OPB: on a byte, WrEn pulse with Address=1 and WrData=byte; go to FUN.
  - FUN: on a byte, ALU_EN pulse with ALU_FUN=byte[3:0]; go to ALU_WAIT.
  - ALU_WAIT: on ALU_OUT_VLD, go to IDLE.
- Address bytes use the low Addr_Width bits. Upper bits are ignored.
- CLK_GATE_EN is high in FUN and ALU_WAIT. On the 0xCC path it is also high from entering OPB onward, so the gated clock is running at least one cycle before ALU_EN. It is low in every other state.
- ALU_FUN holds its last value until the next FUN byte.
- RX_D_VLD in ALU_WAIT is dropped. No buffering.
- Timeout:
  - A counter clears on every state change and every accepted byte, and increments each cycle in any non-IDLE state.
  - When the counter equals Timeout-1 with no RX_D_VLD (WR_ADDR…FUN) or no ALU_OUT_VLD (ALU_WAIT) in that cycle, the next state is IDLE. No strobe is issued.
  - Partial frames never produce WrEn/RdEn/ALU_EN.

## Timing
- All outputs are registered. Reset values: WrEn=0, RdEn=0, ALU_EN=0, CLK_GATE_EN=0, Address=0, WrData=0, ALU_FUN=0. State resets to IDLE and the counter to 0.
- Strobe latency: a byte sampled with RX_D_VLD at edge N produces its strobe (WrEn/RdEn/ALU_EN) high for exactly the cycle following edge N. Address/WrData are valid in the same cycle.
- Address and WrData hold after the strobe until the next strobe.
- CLK_GATE_EN follows the registered state (changes on the edge of the state transition).
- ALU_OUT_VLD arriving in the same cycle as the ALU_EN pulse is ignored. Only ALU_OUT_VLD sampled while in ALU_WAIT, from the edge after ALU_EN onward, completes the operation.
- A byte and a timeout in the same cycle: the byte wins.
- ALU_OUT_VLD outside ALU_WAIT is ignored.
- Back-to-back bytes on consecutive cycles are accepted. There is no minimum gap.
- RST asserted mid-frame: all outputs drop to reset values asynchronously, and the frame is lost.

## Test plan
- Bytes AA,05,3C → one WrEn cycle with Address=5, WrData=0x3C; then IDLE; no RdEn/ALU_EN.
- Bytes BB,07 → one RdEn cycle with Address=7; WrEn stays 0.
- Bytes CC,12,34,01, then ALU_OUT_VLD 3 cycles later:
  - WrEn at addr 0 with 0x12, then WrEn at addr 1 with 0x34.
  - CLK_GATE_EN rises on entering OPB; ALU_EN one cycle with ALU_FUN=1.
  - CLK_GATE_EN falls on the edge after ALU_OUT_VLD.
- Bytes 55, then DD,08 → 0x55 ignored; ALU_EN with ALU_FUN=8; an extra byte 0xAA during ALU_WAIT is dropped (no WR_ADDR entered).
- Timeout=16; AA,03, then silence → IDLE after 16 cycles with no WrEn; the next AA,03,FF writes 0xFF to addr 3. Also check a byte arriving exactly at cycle 15 is accepted.
- RST pulsed low between OPA and OPB bytes → all outputs 0 and CLK_GATE_EN=0 immediately; after release, the following B byte is treated as an IDLE command byte.
